// File: rtl/bmp_stream_writer_if.sv
`timescale 1ns/1ps
// Pixel-in / byte-out handshake bundle for the BMP stream writer.
// master = the writer itself, slave = the framebuffer/SD side driving it.
interface bmp_stream_writer_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    modport master (
        input  pix_valid, pix_data, out_ready,
        output pix_ready, out_valid, out_byte, out_last
    );

    modport slave (
        output pix_valid, pix_data, out_ready,
        input  pix_ready, out_valid, out_byte, out_last
    );
endinterface

// File: rtl/bmp_stream_writer.sv
`timescale 1ns/1ps
// Serializes a WIDTH x HEIGHT 24-bit raster into a BMP byte stream (BGR, rows padded to 4 bytes).
// Latency: start -> first byte next cycle; pixel accept -> B/G/R on the following three cycles.
// Backpressure: output byte held while out_ready is low; pix_ready only when a byte slot is free.
// BMP_STREAM_WRITER_HEADER_EN: when defined, the 54-byte file header precedes the pixel data.
module bmp_stream_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    bmp_stream_writer_if.master   io
);

    localparam logic [31:0] ROW_BYTES = 32'((3 * WIDTH + 3) & ~3);
    localparam logic [31:0] PAD       = ROW_BYTES - 32'(3 * WIDTH);
    localparam logic [1:0]  PAD_LAST  = 2'(PAD - 32'd1);
    localparam bit          HAS_PAD   = (PAD != 32'd0);
    localparam logic [11:0] COL_LAST  = 12'(WIDTH - 1);
    localparam logic [12:0] ROW_LAST  = 13'(HEIGHT - 1);
    localparam logic [12:0] ROW_END   = 13'(HEIGHT);
`ifdef BMP_STREAM_WRITER_HEADER_EN
    localparam logic [31:0] IMG_SIZE  = ROW_BYTES * 32'(HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'd54 + IMG_SIZE;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
`ifdef BMP_STREAM_WRITER_HEADER_EN
        S_HEADER = 3'd1,
`endif
        S_PIXEL  = 3'd2,
        S_PAD    = 3'd3,
        S_LAST   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q;
    logic [11:0] col_q;
    logic [12:0] row_q;
    logic [1:0]  pad_q;
    logic [7:0]  pix_g_q, pix_r_q;
    logic        out_valid_q, out_last_q, done_q;
    logic [7:0]  out_byte_q;
`ifdef BMP_STREAM_WRITER_HEADER_EN
    logic [5:0]  hdr_idx_q;
`endif

    logic        load_en;
    logic        ld_vld, ld_last;
    logic [7:0]  ld_byte;
    logic        busy_c, pix_ready_c;

`ifdef BMP_STREAM_WRITER_HEADER_EN
    // Bytes 2..53 are 13 little-endian words; the two 16-bit fields share word 6.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [5:0]  j;
        logic [31:0] w;
        j = idx - 6'd2;
        case (j[5:2])
            4'd0:        w = FILE_SIZE;
            4'd2:        w = 32'd54;
            4'd3:        w = 32'd40;
            4'd4:        w = 32'(WIDTH);
            4'd5:        w = 32'(HEIGHT);
            4'd6:        w = 32'h0018_0001;
            4'd8:        w = IMG_SIZE;
            4'd9, 4'd10: w = 32'd2835;
            default:     w = 32'd0;
        endcase
        if (idx == 6'd0) return 8'h42;
        if (idx == 6'd1) return 8'h4D;
        return w[{j[1:0], 3'b000} +: 8];
    endfunction
`endif

    // A new byte may enter the output register only when it is empty or draining.
    assign load_en = !out_valid_q || io.out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_vld  = 1'b0;
        ld_last = 1'b0;
        ld_byte = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef BMP_STREAM_WRITER_HEADER_EN
                    state_d = S_HEADER;
                    ld_vld  = 1'b1;
                    ld_byte = hdr_byte(6'd0);
`else
                    state_d = S_PIXEL;
`endif
                end
            end
`ifdef BMP_STREAM_WRITER_HEADER_EN
            S_HEADER: begin
                if (load_en) begin
                    ld_vld  = 1'b1;
                    ld_byte = hdr_byte(hdr_idx_q);
                    if (hdr_idx_q == 6'd53) state_d = S_PIXEL;
                end
            end
`endif
            S_PIXEL: begin
                if (load_en) begin
                    case (phase_q)
                        2'd0: begin
                            ld_vld  = io.pix_valid;
                            ld_byte = io.pix_data[7:0];
                        end
                        2'd1: begin
                            ld_vld  = 1'b1;
                            ld_byte = pix_g_q;
                        end
                        default: begin
                            ld_vld  = 1'b1;
                            ld_byte = pix_r_q;
                            if (col_q == COL_LAST) begin
                                if (HAS_PAD) begin
                                    state_d = S_PAD;
                                end else if (row_q == ROW_LAST) begin
                                    ld_last = 1'b1;
                                    state_d = S_LAST;
                                end
                            end
                        end
                    endcase
                end
            end
            S_PAD: begin
                // Row counter has already advanced here, so the final row shows as ROW_END.
                if (load_en) begin
                    ld_vld = 1'b1;
                    if (pad_q == PAD_LAST) begin
                        if (row_q == ROW_END) begin
                            ld_last = 1'b1;
                            state_d = S_LAST;
                        end else begin
                            state_d = S_PIXEL;
                        end
                    end
                end
            end
            S_LAST: begin
                if (out_valid_q && io.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_c      = (state_q != S_IDLE);
        pix_ready_c = (state_q == S_PIXEL) && (phase_q == 2'd0) && load_en;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            phase_q     <= 2'd0;
            col_q       <= 12'd0;
            row_q       <= 13'd0;
            pad_q       <= 2'd0;
            pix_g_q     <= 8'h00;
            pix_r_q     <= 8'h00;
`ifdef BMP_STREAM_WRITER_HEADER_EN
            hdr_idx_q   <= 6'd0;
`endif
        end else begin
            done_q <= (state_q == S_LAST) && out_valid_q && io.out_ready;
            if (load_en) begin
                out_valid_q <= ld_vld;
                out_last_q  <= ld_vld && ld_last;
                if (ld_vld) out_byte_q <= ld_byte;
            end
            if (state_q == S_IDLE && start) begin
                phase_q <= 2'd0;
                col_q   <= 12'd0;
                row_q   <= 13'd0;
                pad_q   <= 2'd0;
`ifdef BMP_STREAM_WRITER_HEADER_EN
                hdr_idx_q <= 6'd1;
`endif
            end
`ifdef BMP_STREAM_WRITER_HEADER_EN
            if (state_q == S_HEADER && load_en) hdr_idx_q <= hdr_idx_q + 6'd1;
`endif
            if (state_q == S_PIXEL && load_en) begin
                case (phase_q)
                    2'd0: begin
                        if (io.pix_valid) begin
                            phase_q <= 2'd1;
                            pix_g_q <= io.pix_data[15:8];
                            pix_r_q <= io.pix_data[23:16];
                        end
                    end
                    2'd1: phase_q <= 2'd2;
                    default: begin
                        phase_q <= 2'd0;
                        if (col_q == COL_LAST) begin
                            col_q <= 12'd0;
                            row_q <= row_q + 13'd1;
                        end else begin
                            col_q <= col_q + 12'd1;
                        end
                    end
                endcase
            end
            if (state_q == S_PAD && load_en)
                pad_q <= (pad_q == PAD_LAST) ? 2'd0 : pad_q + 2'd1;
        end
    end

    assign busy         = busy_c;
    assign done         = done_q;
    assign io.pix_ready = pix_ready_c;
    assign io.out_valid = out_valid_q;
    assign io.out_byte  = out_byte_q;
    assign io.out_last  = out_last_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
`timescale 1ns/1ps
// Scoreboard bench: expected file bytes are queued per file, a negedge monitor pops and compares.
module tb_bmp_stream_writer;

`ifdef BMP_STREAM_WRITER_HEADER_EN
    localparam int HDR_LEN = 54;
`else
    localparam int HDR_LEN = 0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, done, busy2, done2;

    always #5 clk = ~clk;

    bmp_stream_writer_if bus ();
    bmp_stream_writer_if bus2 ();

    bmp_stream_writer #(.WIDTH(2), .HEIGHT(2)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .io(bus)
    );

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(1)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .busy(busy2), .done(done2), .io(bus2)
    );

    // 2x2 image: FILE_SIZE 70, IMG_SIZE 16
    logic [7:0] hdr1 [54] = '{8'h42, 8'h4D,
        8'h46, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  8'h36, 8'h00, 8'h00, 8'h00,
        8'h28, 8'h00, 8'h00, 8'h00,  8'h02, 8'h00, 8'h00, 8'h00,  8'h02, 8'h00, 8'h00, 8'h00,
        8'h01, 8'h00, 8'h18, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  8'h10, 8'h00, 8'h00, 8'h00,
        8'h13, 8'h0B, 8'h00, 8'h00,  8'h13, 8'h0B, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] dat1 [16] = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h00, 8'h00,
                              8'h99, 8'h88, 8'h77, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00};
    logic [23:0] pix1 [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};

    // 4x1 image, no padding: FILE_SIZE 66, IMG_SIZE 12
    logic [7:0] hdr2 [54] = '{8'h42, 8'h4D,
        8'h42, 8'h00, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  8'h36, 8'h00, 8'h00, 8'h00,
        8'h28, 8'h00, 8'h00, 8'h00,  8'h04, 8'h00, 8'h00, 8'h00,  8'h01, 8'h00, 8'h00, 8'h00,
        8'h01, 8'h00, 8'h18, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,  8'h0C, 8'h00, 8'h00, 8'h00,
        8'h13, 8'h0B, 8'h00, 8'h00,  8'h13, 8'h0B, 8'h00, 8'h00,  8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] dat2 [12] = '{8'h03, 8'h02, 8'h01, 8'h06, 8'h05, 8'h04,
                              8'h09, 8'h08, 8'h07, 8'h0C, 8'h0B, 8'h0A};
    logic [23:0] pix2 [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

    logic [8:0] exp_q [$];
    logic [8:0] exp2_q [$];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int nbytes = 0;
    bit mon_en = 1'b0;
    bit ready_rand = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor for the 2x2 writer: byte order, last flag, hold stability and done timing.
    bit held = 1'b0;
    bit exp_done = 1'b0;
    logic [7:0] held_byte;
    logic held_last;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!mon_en) begin
            held = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_low_at_done", 32'(busy), 32'd0);
                exp_done = 1'b0;
            end else if (done) begin
                chk("spurious_done", 32'(done), 32'd0);
            end
            if (held) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_byte", 32'(bus.out_byte), 32'(held_byte));
                chk("hold_last", 32'(bus.out_last), 32'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL extra_byte: got 0x%02h, expected no byte", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", nbytes), 32'(bus.out_byte), 32'(e[7:0]));
                    chk($sformatf("last%0d", nbytes), 32'(bus.out_last), 32'(e[8]));
                    if (first_cyc < 0) first_cyc = cyc;
                    if (bus.out_last) begin
                        last_cyc = cyc;
                        exp_done = 1'b1;
                    end
                end
                nbytes++;
            end
            held = bus.out_valid && !bus.out_ready;
            held_byte = bus.out_byte;
            held_last = bus.out_last;
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                checks++;
                $display("FAIL dut2_extra_byte: got 0x%02h, expected no byte", bus2.out_byte);
            end else begin
                e = exp2_q.pop_front();
                chk("dut2_byte", 32'(bus2.out_byte), 32'(e[7:0]));
                chk("dut2_last", 32'(bus2.out_last), 32'(e[8]));
            end
        end
    end

    task automatic run_file(input bit rnd, input int gap_after, input bit dup_start);
        bit hs;
        bit seen;
        int t;
        int k;
        ready_rand = rnd;
        first_cyc = -1;
        nbytes = 0;
        for (int i = 0; i < HDR_LEN; i++) exp_q.push_back({1'b0, hdr1[i]});
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), dat1[i]});
        bus.pix_valid = 1'b1;
        bus.pix_data = pix1[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
`ifdef BMP_STREAM_WRITER_HEADER_EN
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_byte", 32'(bus.out_byte), 32'h42);
`else
        chk("first_valid", 32'(bus.out_valid), 32'd0);
`endif
        k = 0;
        for (int i = 0; i < 4; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data = pix1[i];
            hs = 1'b0;
            t = 0;
            while (!hs && t < 400) begin
                @(negedge clk);
                hs = bus.pix_ready;
                @(posedge clk); #1;
                t++; k++;
                start = dup_start && (k == 3);
            end
            if (!hs) begin
                checks++;
                $display("FAIL pix_accept_timeout: pixel %0d not accepted after %0d cycles", i, t);
            end
            bus.pix_valid = 1'b0;
            if (i == gap_after) begin
                repeat (5) begin
                    @(posedge clk); #1;
                    k++;
                    start = dup_start && (k == 3);
                end
                if (!rnd) chk("gap_out_valid", 32'(bus.out_valid), 32'd0);
            end
        end
        start = 1'b0;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 600) begin
            @(negedge clk);
            seen = done;
            t++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        if (!rnd && gap_after < 0)
            chk("file_span", 32'(last_cyc - first_cyc + 1), 32'(HDR_LEN + 16));
        exp_q.delete();
    endtask

    task automatic run_file2();
        bit hs;
        bit seen;
        int t;
        for (int i = 0; i < HDR_LEN; i++) exp2_q.push_back({1'b0, hdr2[i]});
        for (int i = 0; i < 12; i++) exp2_q.push_back({(i == 11), dat2[i]});
        bus2.pix_valid = 1'b1;
        bus2.pix_data = pix2[0];
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus2.pix_valid = 1'b1;
            bus2.pix_data = pix2[i];
            hs = 1'b0;
            t = 0;
            while (!hs && t < 400) begin
                @(negedge clk);
                hs = bus2.pix_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!hs) begin
                checks++;
                $display("FAIL dut2_pix_timeout: pixel %0d not accepted after %0d cycles", i, t);
            end
            bus2.pix_valid = 1'b0;
        end
        seen = 1'b0;
        t = 0;
        while (!seen && t < 300) begin
            @(negedge clk);
            seen = done2;
            t++;
        end
        chk("dut2_done_seen", 32'(seen), 32'd1);
        chk("dut2_busy_at_done", 32'(busy2), 32'd0);
        chk("dut2_queue_empty", 32'(exp2_q.size()), 32'd0);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_data = 24'h0;
        bus.out_ready = 1'b1;
        bus2.pix_valid = 1'b0;
        bus2.pix_data = 24'h0;
        bus2.out_ready = 1'b1;
        #3 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        run_file(1'b0, -1, 1'b0);
        run_file(1'b1, -1, 1'b1);
        run_file(1'b0, 0, 1'b0);

        // Abandon a file mid-PIXEL with an asynchronous reset.
        mon_en = 1'b0;
        ready_rand = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data = pix1[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (HDR_LEN + 4) @(posedge clk);
        #3;
        chk("busy_before_reset", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_byte", 32'(bus.out_byte), 32'd0);
        chk("midrst_out_last", 32'(bus.out_last), 32'd0);
        chk("midrst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_file(1'b0, -1, 1'b0);

        run_file2();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
